// File: rtl/wb_dst_pipe_if.sv
// Bus bundle between the decode stage, the destination pipe and the hazard unit.
// The master drives decode/hazard inputs; the slave (the pipe) drives the stage tags.
interface wb_dst_pipe_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_dst;
  logic             id_wrt;
  logic             stall;
  logic             flush;
  logic             id_accept;
  logic [REG_W-1:0] id_ex_wb_dst;
  logic             id_ex_wrt;
  logic [REG_W-1:0] ex_mem_wb_dst;
  logic             ex_mem_wrt;
  logic [REG_W-1:0] mem_wb_dst;
  logic             mem_wb_wrt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_dst, id_wrt, stall, flush,
    input  id_accept, id_ex_wb_dst, id_ex_wrt, ex_mem_wb_dst, ex_mem_wrt,
           mem_wb_dst, mem_wb_wrt, bubble_cnt
  );

  modport slave (
    input  id_valid, id_dst, id_wrt, stall, flush,
    output id_accept, id_ex_wb_dst, id_ex_wrt, ex_mem_wb_dst, ex_mem_wrt,
           mem_wb_dst, mem_wb_wrt, bubble_cnt
  );
endinterface

// File: rtl/wb_dst_pipe.sv
// Destination-tag pipe through ID/EX, EX/MEM and MEM/WB with stall bubbles,
// branch flush and a saturating stall-bubble counter.
module wb_dst_pipe #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  wb_dst_pipe_if.slave bus
);
  logic [REG_W-1:0] r_idExDst;
  logic             r_idExWrt;
  logic [REG_W-1:0] r_exMemDst;
  logic             r_exMemWrt;
  logic [REG_W-1:0] r_memWbDst;
  logic             r_memWbWrt;
  logic [CNT_W-1:0] r_bubbleCnt;
  logic             w_accept;
  logic             w_newWrt;

  assign w_accept = bus.id_valid & ~bus.stall & ~bus.flush;
  // Writes to R0 are dropped here so downstream hazard checks never see them.
  assign w_newWrt = bus.id_wrt & (bus.id_dst != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idExDst   <= '0;
      r_idExWrt   <= 1'b0;
      r_exMemDst  <= '0;
      r_exMemWrt  <= 1'b0;
      r_memWbDst  <= '0;
      r_memWbWrt  <= 1'b0;
      r_bubbleCnt <= '0;
    end else begin
      r_memWbDst <= r_exMemDst;
      r_memWbWrt <= r_exMemWrt;
      if (bus.flush) begin
        r_exMemDst <= '0;
        r_exMemWrt <= 1'b0;
        r_idExDst  <= '0;
        r_idExWrt  <= 1'b0;
      end else begin
        r_exMemDst <= r_idExDst;
        r_exMemWrt <= r_idExWrt;
        if (w_accept) begin
          r_idExDst <= bus.id_dst;
          r_idExWrt <= w_newWrt;
        end else begin
          r_idExDst <= '0;
          r_idExWrt <= 1'b0;
        end
      end
      if (bus.stall && !bus.flush && (r_bubbleCnt != {CNT_W{1'b1}})) begin
        r_bubbleCnt <= r_bubbleCnt + 1'b1;
      end
    end
  end

  assign bus.id_accept     = w_accept;
  assign bus.id_ex_wb_dst  = r_idExDst;
  assign bus.id_ex_wrt     = r_idExWrt;
  assign bus.ex_mem_wb_dst = r_exMemDst;
  assign bus.ex_mem_wrt    = r_exMemWrt;
  assign bus.mem_wb_dst    = r_memWbDst;
  assign bus.mem_wb_wrt    = r_memWbWrt;
  assign bus.bubble_cnt    = r_bubbleCnt;
endmodule

// File: tb/tb_wb_dst_pipe.sv
// Self-checking bench for wb_dst_pipe: directed steps then random traffic,
// compared against a stage-list model; a 4-bit-counter copy covers saturation.
module tb_wb_dst_pipe;
  typedef struct {
    logic [3:0] dst;
    logic       wrt;
  } entry_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Model: stages[0]=ID/EX, [1]=EX/MEM, [2]=MEM/WB; bubbles is an unbounded tally.
  entry_t      stages[3];
  longint      bubbles;

  wb_dst_pipe_if #(.REG_W(4), .CNT_W(16)) busA ();
  wb_dst_pipe_if #(.REG_W(4), .CNT_W(4))  busB ();

  wb_dst_pipe #(.REG_W(4), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(busA));
  wb_dst_pipe #(.REG_W(4), .CNT_W(4))  dutB (.clk(clk), .rst(rst), .bus(busB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    longint satA;
    longint satB;
    satA = (bubbles > 65535) ? 65535 : bubbles;
    satB = (bubbles > 15) ? 15 : bubbles;
    checkVal("idExDst",   {28'd0, busA.id_ex_wb_dst},  {28'd0, stages[0].dst});
    checkVal("idExWrt",   {31'd0, busA.id_ex_wrt},     {31'd0, stages[0].wrt});
    checkVal("exMemDst",  {28'd0, busA.ex_mem_wb_dst}, {28'd0, stages[1].dst});
    checkVal("exMemWrt",  {31'd0, busA.ex_mem_wrt},    {31'd0, stages[1].wrt});
    checkVal("memWbDst",  {28'd0, busA.mem_wb_dst},    {28'd0, stages[2].dst});
    checkVal("memWbWrt",  {31'd0, busA.mem_wb_wrt},    {31'd0, stages[2].wrt});
    checkVal("bubbleCnt", {16'd0, busA.bubble_cnt},    satA[31:0]);
    checkVal("satMemWbDst", {28'd0, busB.mem_wb_dst},  {28'd0, stages[2].dst});
    checkVal("satBubbleCnt", {28'd0, busB.bubble_cnt}, satB[31:0]);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic w,
                               input logic s, input logic f, input logic r);
    entry_t incoming;
    busA.id_valid = v; busA.id_dst = d; busA.id_wrt = w; busA.stall = s; busA.flush = f;
    busB.id_valid = v; busB.id_dst = d; busB.id_wrt = w; busB.stall = s; busB.flush = f;
    rst = r;
    #1;
    checkVal("idAccept", {31'd0, busA.id_accept}, {31'd0, v & ~s & ~f});
    @(posedge clk);
    if (r) begin
      foreach (stages[i]) stages[i] = '{dst: 4'd0, wrt: 1'b0};
      bubbles = 0;
    end else begin
      incoming = '{dst: 4'd0, wrt: 1'b0};
      if (v && !s && !f) incoming = '{dst: d, wrt: w && (d != 4'd0)};
      stages[2] = stages[1];
      stages[1] = f ? '{dst: 4'd0, wrt: 1'b0} : stages[0];
      stages[0] = incoming;
      if (s && !f) bubbles++;
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [3:0] rd;
    logic       rv, rw, rs, rf;
    checks  = 0;
    errors  = 0;
    bubbles = 0;
    foreach (stages[i]) stages[i] = '{dst: 4'd0, wrt: 1'b0};

    // Reset wins over stall, flush and a valid decode instruction.
    applyStimulus(1, 4'd6, 1, 1, 1, 1);
    applyStimulus(1, 4'd6, 1, 1, 1, 1);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);

    // Straight flow of three writers, then drain.
    applyStimulus(1, 4'd3, 1, 0, 0, 0);
    applyStimulus(1, 4'd5, 1, 0, 0, 0);
    applyStimulus(1, 4'd7, 1, 0, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);

    // Two stalled cycles with older entries draining, then dst 9 enters.
    applyStimulus(1, 4'd2, 1, 0, 0, 0);
    applyStimulus(1, 4'd9, 1, 1, 0, 0);
    applyStimulus(1, 4'd9, 1, 1, 0, 0);
    applyStimulus(1, 4'd9, 1, 0, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);

    // Flush together with stall: no count, both young stages annulled.
    applyStimulus(1, 4'd4, 1, 0, 0, 0);
    applyStimulus(1, 4'd8, 1, 1, 1, 0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);

    // Write to R0 is suppressed all the way to MEM/WB.
    applyStimulus(1, 4'd0, 1, 0, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);

    // Long stall saturates the 4-bit counter, then a mid-run reset clears it.
    for (int i = 0; i < 20; i++) applyStimulus(i[0], 4'd11, 1, 1, 0, 0);
    applyStimulus(1, 4'd12, 1, 0, 0, 0);
    applyStimulus(1, 4'd13, 1, 0, 0, 1);
    applyStimulus(0, 4'd0, 0, 0, 0, 0);

    // Random traffic with biased stall/flush rates.
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rd = 4'($urandom_range(0, 15));
      rw = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 2) == 0);
      rf = ($urandom_range(0, 7) == 0);
      applyStimulus(rv, rd, rw, rs, rf, ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_dst_pipe.md
Name: wb_dst_pipe

Overview:
- Carries each instruction's destination-register tag and write-enable through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives the per-stage {dst, wrt} pairs that the hazard detection unit consumes, and acts on that unit's stall output by inserting bubbles.
- Takes a flush from branch resolution and keeps a saturating count of stall bubbles for performance monitoring.
- Sits between the decode stage and the hazard detection unit.

Parameters:
REG_W, 4, width of a register tag (16 architectural registers; R0 is hardwired zero)
CNT_W, 16, width of the stall-bubble counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  decode stage presents a real instruction this cycle
id_dst  input  REG_W  destination register of the decode-stage instruction
id_wrt  input  1  decode-stage instruction writes the register file
stall  input  1  stall request from the hazard detection unit
flush  input  1  branch taken; annul the younger instructions
id_accept  output  1  combinational; decode instruction enters ID/EX at this edge
id_ex_wb_dst  output  REG_W  ID/EX destination tag
id_ex_wrt  output  1  ID/EX write-enable
ex_mem_wb_dst  output  REG_W  EX/MEM destination tag
ex_mem_wrt  output  1  EX/MEM write-enable
mem_wb_dst  output  REG_W  MEM/WB destination tag, also the register-file write address
mem_wb_wrt  output  1  MEM/WB write-enable, also the register-file write strobe
bubble_cnt  output  CNT_W  number of stall-induced bubbles since reset

Behaviour:
- Reset (rst=1 at a clock edge):
  - All dst and wrt registers go to 0.
  - bubble_cnt goes to 0.
  - rst overrides stall and flush.
  - rst mid-stream discards all in-flight entries; outputs are valid from the first cycle after rst deasserts.
- Bubble: an entry with dst=0 and wrt=0.
- R0 rule: an incoming entry's wrt is forced to 0 when id_dst==0. Stored dst keeps the incoming value.
- id_accept = id_valid & ~stall & ~flush (combinational, no register).
- Each non-reset edge, evaluated in this priority order:
  - MEM/WB <= EX/MEM unconditionally. There is no back-pressure past ID/EX.
  - If flush: EX/MEM <= bubble and ID/EX <= bubble. This annuls the ID/EX occupant and the decode instruction; flush wins over stall.
  - Else if stall: EX/MEM <= ID/EX and ID/EX <= bubble. The decode instruction is not accepted; decode must hold id_* stable until id_accept=1.
  - Else if id_valid: EX/MEM <= ID/EX and ID/EX <= {id_dst, id_wrt & (id_dst!=0)}.
  - Else: EX/MEM <= ID/EX and ID/EX <= bubble (idle; no count).
- Latency: an accepted entry appears on id_ex_* 1 cycle after acceptance, on ex_mem_* after 2 cycles, and on mem_wb_* after 3 cycles, provided no flush occurs while it sits in ID/EX.
- bubble_cnt:
  - Increments by 1 on each edge where stall=1, flush=0 and rst=0. This counts whether or not id_valid is high.
  - Saturates at all-ones and never wraps.
  - Flush and idle cycles are not counted.
- Stall held for N consecutive cycles inserts N bubbles. The older entries drain normally, so after 3 stalled cycles all three stages are bubbles.
- The block has no state machine beyond these stage registers and the counter. All outputs are registered except id_accept.

Test Plan:
- Reset: hold rst=1 with stall=1, flush=1 and id_valid=1 → all *_wrt=0, all *_dst=0, bubble_cnt=0. After release with idle inputs, outputs stay 0.
- Straight flow: issue dst=3,5,7 (wrt=1) on consecutive cycles → id_ex_wb_dst=3 at cycle 1, ex_mem_wb_dst=3 at cycle 2, mem_wb_dst=3/mem_wb_wrt=1 at cycle 3; 5 and 7 follow 1 and 2 cycles behind.
- Stall: present dst=9 wrt=1 with stall=1 for 2 cycles, then stall=0 → id_accept=0 for 2 cycles, id_ex_wrt=0 for those 2 cycles, dst 9 enters ID/EX on the 3rd edge, bubble_cnt=2. Older entries keep draining during the stall.
- Flush with stall: ID/EX holds dst=4 wrt=1; assert flush=1 and stall=1 with id_valid=1 → next cycle ex_mem_wrt=0 and id_ex_wrt=0, bubble_cnt unchanged, mem_wb_* still receives the previous EX/MEM contents.
- R0 suppression: issue id_dst=0 with id_wrt=1 → id_ex_wrt=0, and the entry reaches MEM/WB with wrt=0.
- Saturation: with CNT_W=4, hold stall=1 for 20 cycles → bubble_cnt reaches 15 and stays at 15. A mid-run rst returns it to 0.
